// File: rtl/wtr_regfile.sv
// Register file with a one-entry write pipeline, one-hot commit strobe and registered read port.
// Latency: write accepted in cycle N is visible in wtr_dec/contents in N+2; reads have one cycle latency.
// Backpressure: wtr_ready drops only while an entry is pending and wtr_hold freezes the commit stage.
// Optional saturating drop counter on err_cnt is enabled by defining WTR_ERR_CNT_EN.
module wtr_regfile #(
    parameter int NUM_REGS = 15,
    parameter int DATA_W   = 16,
    parameter int SEL_W    = 8,
    parameter int COREID   = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wtr_valid,
    output logic                wtr_ready,
    input  logic [SEL_W-1:0]    wtr_sel,
    input  logic [DATA_W-1:0]   wtr_data,
    input  logic                wtr_hold,
    output logic [NUM_REGS-1:0] wtr_dec,
    input  logic [SEL_W-1:0]    rd_sel,
    output logic [DATA_W-1:0]   rd_data,
    output logic                err,
    output logic [7:0]          err_cnt
);

    // The last select is the read-only CoreID register; it never holds a flop.
    localparam logic [SEL_W-1:0]  LP_CORE_SEL = SEL_W'(NUM_REGS);
    localparam logic [DATA_W-1:0] LP_COREID   = DATA_W'(COREID);

    logic                r_pend;
    logic [SEL_W-1:0]    r_psel;
    logic [DATA_W-1:0]   r_pdata;
    logic [DATA_W-1:0]   r_regs [1:NUM_REGS-1];
    logic [NUM_REGS-1:0] r_dec;
    logic                r_err;
    logic [DATA_W-1:0]   r_rd;

    logic                w_accept;
    logic                w_commit;
    logic                w_sel_ok;
    logic                w_wr_ok;
    logic [NUM_REGS-1:0] w_dec_nxt;
    logic [DATA_W-1:0]   w_rd_nxt;

    assign wtr_ready = !r_pend || !wtr_hold;
    assign w_accept  = wtr_valid && wtr_ready;
    assign w_commit  = r_pend && !wtr_hold;
    assign w_sel_ok  = (r_psel != '0) && (r_psel < LP_CORE_SEL);
    assign w_wr_ok   = w_commit && w_sel_ok;

    assign wtr_dec = r_dec;
    assign err     = r_err;
    assign rd_data = r_rd;

    // Pending stage: a new accept overrides the clear caused by a same-cycle commit.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pend  <= 1'b0;
            r_psel  <= '0;
            r_pdata <= '0;
        end else if (w_accept) begin
            r_pend  <= 1'b1;
            r_psel  <= wtr_sel;
            r_pdata <= wtr_data;
        end else if (w_commit) begin
            r_pend  <= 1'b0;
        end
    end

    // Register array: only in-range, writable selects are loaded on commit.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_wr_ok && (r_psel == SEL_W'(i))) begin
                    r_regs[i] <= r_pdata;
                end
            end
        end
    end

    // One-hot decode of the committing select; the CoreID bit can never be set.
    always_comb begin
        w_dec_nxt = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            w_dec_nxt[i-1] = w_wr_ok && (r_psel == SEL_W'(i));
        end
    end

    // Read mux with forwarding of a same-cycle commit; out-of-range selects read zero.
    always_comb begin
        w_rd_nxt = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                w_rd_nxt = r_regs[i];
            end
        end
        if (rd_sel == LP_CORE_SEL) begin
            w_rd_nxt = LP_COREID;
        end
        if (w_wr_ok && (r_psel == rd_sel)) begin
            w_rd_nxt = r_pdata;
        end
    end

    // Registered outputs: strobe, drop pulse and read data.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dec <= '0;
            r_err <= 1'b0;
            r_rd  <= '0;
        end else begin
            r_dec <= w_dec_nxt;
            r_err <= w_commit && !w_sel_ok;
            r_rd  <= w_rd_nxt;
        end
    end

`ifdef WTR_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    // Drop counter advances together with the err pulse and sticks at 255.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_err_cnt <= '0;
        end else if (w_commit && !w_sel_ok && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 8'd0;
`endif

endmodule
